// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial RAM port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } arb_state_t;

  // Access length is encoded as bytes-1
  localparam logic [1:0] MemLen_Byte = 2'd0;
  localparam logic [1:0] MemLen_Half = 2'd1;
  localparam logic [1:0] MemLen_Word = 2'd3;

  localparam int RAMAddrLen = 32;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  // The unused encoding 2 is promoted to a full word
  function automatic logic [1:0] norm_len(input logic [1:0] len);
    case (len)
      MemLen_Byte: return MemLen_Byte;
      MemLen_Half: return MemLen_Half;
      default:     return MemLen_Word;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port shared by fetch and MEM (MEM wins); word read done grant+5, word store grant+4.
// rdy low freezes all state; every done is followed by one idle cycle before the next grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAMAddrLen,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  arb_state_t        state;
  logic [2:0]        cnt;
  logic [1:0]        len;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] asm_q;

  logic [2:0]        cnt_inc;
  logic [1:0]        lane_prev;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] asm_next;
  logic              read_tail;
  logic              grant_ok;

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        lane,
                                                 input logic [7:0]        b);
    logic [DATA_W-1:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] w,
                                          input logic [1:0]        lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

  // RAM read data lags the address by one cycle, so state cnt=k lands byte k-1
  always_comb begin
    cnt_inc   = cnt + 3'd1;
    lane_prev = cnt[1:0] - 2'd1;
    addr_inc  = base + ADDR_W'(cnt_inc);
    asm_next  = put_byte(asm_q, lane_prev, ram_din);
    read_tail = (cnt > {1'b0, len});
    grant_ok  = !if_done && !mem_done;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      len       <= MemLen_Byte;
      base      <= '0;
      wdata     <= '0;
      asm_q     <= '0;
      ram_a     <= '0;
      ram_dout  <= 8'h00;
      ram_wr    <= Disable;
      if_done   <= Disable;
      mem_done  <= Disable;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else if (rdy) begin
      if_done  <= Disable;
      mem_done <= Disable;
      unique case (state)
        ST_IDLE: begin
          ram_wr <= Disable;
          if (grant_ok) begin
            if (mem_req) begin
              base  <= mem_addr;
              len   <= norm_len(mem_len);
              wdata <= mem_wdata;
              asm_q <= '0;
              cnt   <= 3'd0;
              ram_a <= mem_addr;
              if (mem_we) begin
                state    <= ST_STORE;
                ram_dout <= mem_wdata[7:0];
                ram_wr   <= Enable;
              end else begin
                state <= ST_LOAD;
              end
            end else if (if_req && !flush) begin
              state <= ST_FETCH;
              base  <= if_addr;
              len   <= MemLen_Word;
              asm_q <= '0;
              cnt   <= 3'd0;
              ram_a <= if_addr;
            end
          end
        end

        ST_FETCH, ST_LOAD: begin
          if (state == ST_FETCH && flush) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
          end else if (read_tail) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            asm_q <= asm_next;
            if (state == ST_FETCH) begin
              if_inst <= asm_next;
              if_done <= Enable;
            end else begin
              mem_rdata <= asm_next;
              mem_done  <= Enable;
            end
          end else begin
            if (cnt != 3'd0) begin
              asm_q <= asm_next;
            end
            cnt <= cnt_inc;
            if (cnt < {1'b0, len}) begin
              ram_a <= addr_inc;
            end
          end
        end

        ST_STORE: begin
          if (cnt < {1'b0, len}) begin
            cnt      <= cnt_inc;
            ram_a    <= addr_inc;
            ram_dout <= get_byte(wdata, cnt_inc[1:0]);
            ram_wr   <= Enable;
          end else begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            ram_wr   <= Disable;
            mem_done <= Enable;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
